// File: rtl/itch_pkg.sv
// Shared ITCH result definitions: parsed-type codes, payload field widths and
// the packed result record used between the decoders and the collector.
package itch_pkg;
   localparam int ITCH_TYPE_W = 4;
   localparam int ORDER_REF_W = 64;
   localparam int SHARES_W    = 32;
   localparam int PRICE_W     = 32;
   localparam int MISC_W      = 64;
   localparam int BODY_W      = ORDER_REF_W + SHARES_W + PRICE_W + MISC_W;

   typedef enum logic [ITCH_TYPE_W-1:0] {
      ITCH_ADD     = 4'h1,
      ITCH_CANCEL  = 4'h2,
      ITCH_DELETE  = 4'h3,
      ITCH_REPLACE = 4'h4,
      ITCH_EXEC    = 4'h5,
      ITCH_TRADE   = 4'h6
   } itch_type_e;

   typedef struct packed {
      logic [ITCH_TYPE_W-1:0] msg_type;
      logic [ORDER_REF_W-1:0] order_ref;
      logic [SHARES_W-1:0]    shares;
      logic [PRICE_W-1:0]     price;
      logic [MISC_W-1:0]      misc;
   } itch_result_t;
endpackage

// File: rtl/itch_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty so
// nothing stale is ever presented after reset.
module itch_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_level == '0);
   assign full      = (r_level == (PTR_W+1)'(DEPTH));
   assign w_do_pop  = pop && !empty;
   // A pop frees the head slot this cycle, so a push at full is still legal.
   assign w_do_push = push && (!full || w_do_pop);
   assign level     = r_level;
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (PTR_W+1)'(1);
            2'b01:   r_level <= r_level - (PTR_W+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: rtl/itch_result_arbiter.sv
// Collects per-channel decoder results into holding slots, picks one per cycle
// round-robin and queues it with its source channel in an output FIFO.
module itch_result_arbiter
   import itch_pkg::*;
#(
   parameter int NUM_CH     = 6,
   parameter int FIFO_DEPTH = 8,
   parameter int TYPE_W     = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             ch_valid,
   input  logic [NUM_CH*TYPE_W-1:0]      ch_type,
   input  logic [NUM_CH*64-1:0]          ch_order_ref,
   input  logic [NUM_CH*32-1:0]          ch_shares,
   input  logic [NUM_CH*32-1:0]          ch_price,
   input  logic [NUM_CH*64-1:0]          ch_misc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [TYPE_W-1:0]             out_type,
   output logic [63:0]                   out_order_ref,
   output logic [31:0]                   out_shares,
   output logic [31:0]                   out_price,
   output logic [63:0]                   out_misc,
   output logic [$clog2(NUM_CH)-1:0]     out_channel,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              drop_count,
   output logic [NUM_CH-1:0]             ch_overflow
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PAY_W = TYPE_W + BODY_W;
   localparam int ENT_W = CH_W + PAY_W;
   localparam int DN_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = CNT_W + DN_W;

   logic [PAY_W-1:0]  w_in_pay [NUM_CH];
   logic [PAY_W-1:0]  r_slot   [NUM_CH];
   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_overflow;
   logic [CNT_W-1:0]  r_drop_count;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   w_gnt_ch;
   logic [CH_W-1:0]   w_idx;
   logic [NUM_CH-1:0] w_gnt_1h;
   logic [NUM_CH-1:0] w_drop;
   logic [DN_W-1:0]   w_drop_n;
   logic [SUM_W-1:0]  w_sum;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_gnt_vld;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic              w_can_push;
   logic [ENT_W-1:0]  w_fifo_din;
   logic [ENT_W-1:0]  w_fifo_dout;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_in
      assign w_in_pay[gi] = {ch_type[gi*TYPE_W +: TYPE_W], ch_order_ref[gi*64 +: 64],
                             ch_shares[gi*32 +: 32], ch_price[gi*32 +: 32], ch_misc[gi*64 +: 64]};
   end

   assign out_valid  = !w_empty;
   assign w_pop      = out_valid && out_ready;
   assign w_can_push = !w_full || w_pop;

   // Search starts just past the last winner so every pending channel is reached.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_ch  = '0;
      w_idx     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
         if (!w_gnt_vld && w_can_push && r_pend[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = w_idx;
         end
      end
   end

   assign w_gnt_1h   = w_gnt_vld ? (NUM_CH'(1) << w_gnt_ch) : '0;
   assign w_drop     = ch_valid & r_pend & ~w_gnt_1h;
   assign w_drop_n   = DN_W'($countones(w_drop));
   assign w_sum      = SUM_W'(r_drop_count) + SUM_W'(w_drop_n);
   assign w_cnt_next = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend       <= '0;
         r_overflow   <= '0;
         r_drop_count <= '0;
         r_rr_ptr     <= CH_W'(NUM_CH - 1);
         for (int i = 0; i < NUM_CH; i++) r_slot[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            // A strobe on the granting cycle refills the slot being drained.
            if (ch_valid[i] && (!r_pend[i] || w_gnt_1h[i])) begin
               r_slot[i] <= w_in_pay[i];
               r_pend[i] <= 1'b1;
            end else if (w_gnt_1h[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
         if (w_gnt_vld) r_rr_ptr <= w_gnt_ch;
         r_drop_count <= w_cnt_next;
         r_overflow   <= r_overflow | w_drop;
      end
   end

   assign w_fifo_din = {w_gnt_ch, r_slot[w_gnt_ch]};

   itch_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_gnt_vld),
      .din   (w_fifo_din),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty),
      .level (fifo_level)
   );

   assign {out_channel, out_type, out_order_ref, out_shares, out_price, out_misc} = w_fifo_dout;
   assign drop_count  = r_drop_count;
   assign ch_overflow = r_overflow;
endmodule

// File: tb/tb_itch_result_arbiter.sv
// Scoreboard bench for itch_result_arbiter: scenario tasks push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_itch_result_arbiter;
   import itch_pkg::*;

   localparam int NUM_CH = 6;
   localparam int FIFO_DEPTH = 8;
   localparam int TYPE_W = 4;
   localparam int CNT_W = 16;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_CH-1:0]       ch_valid = '0;
   logic [NUM_CH*TYPE_W-1:0] ch_type = '0;
   logic [NUM_CH*64-1:0]    ch_order_ref = '0;
   logic [NUM_CH*32-1:0]    ch_shares = '0;
   logic [NUM_CH*32-1:0]    ch_price = '0;
   logic [NUM_CH*64-1:0]    ch_misc = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [TYPE_W-1:0]       out_type;
   logic [63:0]             out_order_ref;
   logic [31:0]             out_shares;
   logic [31:0]             out_price;
   logic [63:0]             out_misc;
   logic [2:0]              out_channel;
   logic [3:0]              fifo_level;
   logic [CNT_W-1:0]        drop_count;
   logic [NUM_CH-1:0]       ch_overflow;

   typedef struct packed {
      logic [2:0]   ch;
      itch_result_t r;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_got;
   exp_t         mon_exp;
   itch_result_t cur [NUM_CH];
   int n_checks = 0;
   int n_errors = 0;
   int n_beats = 0;

   always #5 clk = ~clk;

   itch_result_arbiter #(
      .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .TYPE_W(TYPE_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_type(ch_type),
      .ch_order_ref(ch_order_ref), .ch_shares(ch_shares), .ch_price(ch_price),
      .ch_misc(ch_misc), .out_valid(out_valid), .out_ready(out_ready),
      .out_type(out_type), .out_order_ref(out_order_ref), .out_shares(out_shares),
      .out_price(out_price), .out_misc(out_misc), .out_channel(out_channel),
      .fifo_level(fifo_level), .drop_count(drop_count), .ch_overflow(ch_overflow)
   );

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         mon_got.ch = out_channel;
         mon_got.r.msg_type = out_type;
         mon_got.r.order_ref = out_order_ref;
         mon_got.r.shares = out_shares;
         mon_got.r.price = out_price;
         mon_got.r.misc = out_misc;
         n_beats++;
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_beat: got ch=%0d ref=%h, required no output", out_channel, out_order_ref);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               n_errors++;
               $display("FAIL beat: got ch=%0d type=%h ref=%h sh=%h pr=%h misc=%h, required ch=%0d type=%h ref=%h sh=%h pr=%h misc=%h",
                        mon_got.ch, mon_got.r.msg_type, mon_got.r.order_ref, mon_got.r.shares, mon_got.r.price, mon_got.r.misc,
                        mon_exp.ch, mon_exp.r.msg_type, mon_exp.r.order_ref, mon_exp.r.shares, mon_exp.r.price, mon_exp.r.misc);
            end else begin
               $display("beat %0d: ch=%0d type=%h ref=%h ok", n_beats, out_channel, out_type, out_order_ref);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int ch, input itch_result_t r);
      ch_type[ch*TYPE_W +: TYPE_W] = r.msg_type;
      ch_order_ref[ch*64 +: 64] = r.order_ref;
      ch_shares[ch*32 +: 32] = r.shares;
      ch_price[ch*32 +: 32] = r.price;
      ch_misc[ch*64 +: 64] = r.misc;
      cur[ch] = r;
   endtask

   task automatic rand_load(input int ch);
      itch_result_t r;
      r.msg_type = 4'($urandom_range(1, 6));
      r.order_ref = {$urandom(), $urandom()};
      r.shares = $urandom();
      r.price = $urandom();
      r.misc = {$urandom(), $urandom()};
      load(ch, r);
   endtask

   task automatic pulse(input logic [NUM_CH-1:0] mask);
      for (int i = 0; i < NUM_CH; i++) if (mask[i]) rand_load(i);
      ch_valid = mask;
      tick();
      ch_valid = '0;
   endtask

   task automatic expect_ch(input int ch);
      sb.push_back({3'(ch), cur[ch]});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      sb.delete();
      tick();
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (2) tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      n_checks++; if (drop_count !== '0) begin n_errors++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
      n_checks++; if (ch_overflow !== '0) begin n_errors++; $display("FAIL reset_overflow: got %b, required 0", ch_overflow); end
      n_checks++; if ({out_channel, out_order_ref, out_type} !== '0) begin n_errors++; $display("FAIL reset_payload: got ch=%0d ref=%h, required 0", out_channel, out_order_ref); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      itch_result_t r;
      out_ready = 1'b1;
      r.msg_type = 4'h3; r.order_ref = 64'hA5; r.shares = 32'd100; r.price = 32'd12345; r.misc = 64'h1122;
      load(2, r);
      expect_ch(2);
      ch_valid = 6'b000100;
      tick();
      ch_valid = '0;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_t1_valid: got %b, required 0", out_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_t2_valid: got %b, required 1", out_valid); end
      n_checks++; if (out_channel !== 3'd2) begin n_errors++; $display("FAIL single_channel: got %0d, required 2", out_channel); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_t3_valid: got %b, required 0", out_valid); end
      n_checks++; if (drop_count !== '0) begin n_errors++; $display("FAIL single_drop: got %0d, required 0", drop_count); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL single_pending: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_all_channels();
      int b0;
      int peak;
      do_reset();
      out_ready = 1'b1;
      b0 = n_beats;
      peak = 0;
      pulse(6'b111111);
      for (int i = 0; i < NUM_CH; i++) expect_ch(i);
      repeat (10) begin
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         tick();
      end
      n_checks++; if (peak != 1) begin n_errors++; $display("FAIL all_peak_level: got %0d, required 1", peak); end
      n_checks++; if (n_beats - b0 != 6) begin n_errors++; $display("FAIL all_beats: got %0d, required 6", n_beats - b0); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL all_pending: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int b0;
      do_reset();
      out_ready = 1'b0;
      b0 = n_beats;
      pulse(6'b111111);
      for (int i = 0; i < NUM_CH; i++) expect_ch(i);
      repeat (3) tick();
      pulse(6'b001111);
      for (int i = 0; i < 4; i++) expect_ch(i);
      repeat (2) tick();
      n_checks++; if (fifo_level !== 4'd6) begin n_errors++; $display("FAIL bp_level6: got %0d, required 6", fifo_level); end
      repeat (5) tick();
      n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL bp_level8: got %0d, required 8", fifo_level); end
      n_checks++; if (drop_count !== '0) begin n_errors++; $display("FAIL bp_drop: got %0d, required 0", drop_count); end
      out_ready = 1'b1;
      repeat (14) tick();
      n_checks++; if (n_beats - b0 != 10) begin n_errors++; $display("FAIL bp_beats: got %0d, required 10", n_beats - b0); end
      n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL bp_level_end: got %0d, required 0", fifo_level); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL bp_pending: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_overflow();
      int b0;
      do_reset();
      out_ready = 1'b0;
      b0 = n_beats;
      pulse(6'b111111);
      for (int i = 0; i < NUM_CH; i++) expect_ch(i);
      repeat (7) tick();
      pulse(6'b110000);
      expect_ch(4);
      expect_ch(5);
      repeat (3) tick();
      n_checks++; if (fifo_level !== 4'd8) begin n_errors++; $display("FAIL ovf_full: got %0d, required 8", fifo_level); end
      pulse(6'b000010);
      expect_ch(1);
      tick();
      pulse(6'b000010);
      n_checks++; if (drop_count !== 16'd1) begin n_errors++; $display("FAIL ovf_drop: got %0d, required 1", drop_count); end
      n_checks++; if (ch_overflow !== 6'b000010) begin n_errors++; $display("FAIL ovf_flags: got %b, required 000010", ch_overflow); end
      out_ready = 1'b1;
      repeat (16) tick();
      n_checks++; if (n_beats - b0 != 9) begin n_errors++; $display("FAIL ovf_beats: got %0d, required 9", n_beats - b0); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL ovf_pending: got %0d left, required 0", sb.size()); end
      n_checks++; if (drop_count !== 16'd1 || ch_overflow !== 6'b000010) begin n_errors++; $display("FAIL ovf_sticky: got drop=%0d flags=%b, required 1/000010", drop_count, ch_overflow); end
   endtask

   task automatic test_reset_mid();
      int b0;
      do_reset();
      out_ready = 1'b0;
      pulse(6'b011111);
      repeat (5) tick();
      pulse(6'b000111);
      n_checks++; if (fifo_level !== 4'd5) begin n_errors++; $display("FAIL rmid_pre_level: got %0d, required 5", fifo_level); end
      rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_async_valid: got %b, required 0", out_valid); end
      n_checks++; if (fifo_level !== 4'd0) begin n_errors++; $display("FAIL rmid_async_level: got %0d, required 0", fifo_level); end
      sb.delete();
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      b0 = n_beats;
      repeat (12) tick();
      n_checks++; if (n_beats - b0 != 0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_stale: got %0d beats valid=%b, required 0 beats", n_beats - b0, out_valid); end
      pulse(6'b001000);
      expect_ch(3);
      repeat (4) tick();
      n_checks++; if (n_beats - b0 != 1) begin n_errors++; $display("FAIL rmid_new: got %0d beats, required 1", n_beats - b0); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL rmid_pending: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_fairness();
      localparam int N = 12;
      itch_result_t v0 [N];
      itch_result_t v3 [N];
      int b0;
      int j;
      int src;
      do_reset();
      out_ready = 1'b1;
      b0 = n_beats;
      // Winner of cycle j carries what its slot last captured, two cycles earlier.
      for (int k = 0; k < N; k++) begin
         rand_load(0);
         rand_load(3);
         v0[k] = cur[0];
         v3[k] = cur[3];
         j = k + 1;
         src = (j >= 2) ? j - 2 : 0;
         if (j % 2 == 1) sb.push_back({3'd0, v0[src]});
         else sb.push_back({3'd3, v3[src]});
         ch_valid = 6'b001001;
         tick();
      end
      ch_valid = '0;
      sb.push_back({3'd0, v0[N-1]});
      repeat (6) tick();
      n_checks++; if (n_beats - b0 != N + 1) begin n_errors++; $display("FAIL fair_beats: got %0d, required %0d", n_beats - b0, N + 1); end
      n_checks++; if (drop_count !== 16'(N - 1)) begin n_errors++; $display("FAIL fair_drop: got %0d, required %0d", drop_count, N - 1); end
      n_checks++; if (ch_overflow !== 6'b001001) begin n_errors++; $display("FAIL fair_flags: got %b, required 001001", ch_overflow); end
      n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL fair_pending: got %0d left, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_channels();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_fairness();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/itch_result_arbiter.md
# itch_result_arbiter

Parametrised collector between the per-type ITCH decoders and the downstream consumer. It replaces the single-cycle priority mux with three stages: per-channel holding slots, a round-robin arbiter and a FIFO with a ready/valid output. Simultaneous or back-to-back decoder results are no longer lost. It reports the source channel and counts dropped results.

## Interface
Parameters:
- NUM_CH, 6: number of decoder channels; ≥2.
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥2.
- TYPE_W, 4: parsed-type width.
- CNT_W, 16: drop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_valid  in  NUM_CH  one-cycle result strobe per channel.
- ch_type  in  NUM_CH*TYPE_W  parsed type per channel; channel i at [i*TYPE_W +: TYPE_W].
- ch_order_ref  in  NUM_CH*64  order reference per channel.
- ch_shares  in  NUM_CH*32  share count per channel.
- ch_price  in  NUM_CH*32  price per channel.
- ch_misc  in  NUM_CH*64  misc data per channel: new ref, match id or symbol.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_type, out_order_ref, out_shares, out_price, out_misc  out  TYPE_W/64/32/32/64  head payload.
- out_channel  out  $clog2(NUM_CH)  source channel of the head.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- drop_count  out  CNT_W  saturating count of dropped results.
- ch_overflow  out  NUM_CH  sticky per-channel drop flag.

## Operation
- **Slots:** one slot per channel (payload plus `pend[i]`).
  - ch_valid[i] with pend[i]=0: capture the payload and set pend[i].
  - ch_valid[i] with pend[i]=1 and channel i not granted this cycle: discard the new result, keep the old one, increment drop_count and set ch_overflow[i].
  - ch_valid[i] on the cycle channel i is granted: reload the slot and keep pend[i]=1. This is not a drop.
- **Arbiter:**
  - Each cycle, if `can_push`, grant the first set pend[] searching from rr_ptr+1 upward modulo NUM_CH.
  - `can_push` = (level < FIFO_DEPTH) or a pop occurs this cycle.
  - On grant: push {slot payload, channel}, clear pend (unless reloaded), set rr_ptr to the granted channel.
  - At most one grant per cycle. No grant means no push.
- **FIFO:**
  - First-word-fall-through. out_valid = (level ≠ 0).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave level unchanged, including at full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - When out_valid=0, out_ready is ignored and the payload outputs are don't-care.
- **drop_count:** saturates at all-ones. Drops on several channels in one cycle add the number of dropping channels, saturating.
- **ch_overflow:** cleared only by reset.

## Timing
- Reset values (asserted asynchronously): pend=0, rr_ptr=NUM_CH-1 so channel 0 is searched first, FIFO empty, out_valid=0, fifo_level=0, drop_count=0, ch_overflow=0, all payload and out_channel outputs 0.
- Reset asserted mid-burst discards all slots and FIFO contents immediately. No stale data appears after release.
- Latency with an idle system: ch_valid high in cycle t, slot written at edge t, granted and pushed in t+1, out_valid=1 in cycle t+2.
- Throughput: one result per cycle in and out when out_ready=1.
- Sustained rate above one result per cycle across channels is absorbed by the slots. A drop occurs only when a channel strobes again before its slot is granted.
- Out of reset, a burst with all channels pending emerges in channel order 0,1,…,NUM_CH-1.

## Structure
- Package itch_pkg:
  - parsed-type encodings (add, cancel, delete, replace, exec, trade).
  - packed struct `itch_result_t` {type, order_ref, shares, price, misc}.
  - width localparams (ORDER_REF_W=64, SHARES_W=32, PRICE_W=32, MISC_W=64).
- Sub-module itch_sync_fifo:
  - parameters WIDTH, DEPTH.
  - ports: push, pop, full, empty, level, async active-low reset.
  - Arbiter and slots stay in itch_result_arbiter.

## Test plan
- **Single result:** one ch_valid[2] pulse, type=4'h3, order_ref=64'hA5, out_ready=1 → out_valid high for exactly one cycle at t+2, out_channel=2, out_order_ref=64'hA5, drop_count=0.
- **All channels at once:** all six ch_valid in the same cycle, out_ready=1 → six consecutive beats with out_channel 0,1,2,3,4,5 and payloads matching, fifo_level peaks at 1.
- **Backpressure:** out_ready=0, one pulse on each of ch0–ch5, then ch0–ch3 again four cycles later → fifo_level=6, then 8 after the second wave, no drops; release out_ready → 10 beats in arbitration order, level returns to 0.
- **Overflow:** out_ready=0, FIFO full, two ch_valid[1] pulses 2 cycles apart → drop_count=1, ch_overflow=6'b000010; the first ch1 payload is delivered after release, the second is never delivered.
- **Reset mid-operation:** rst low for 1 cycle with fifo_level=5 and 3 slots pending → out_valid=0 and fifo_level=0 asynchronously; after release, nothing is output until new strobes arrive.
- **Fairness:** ch0 and ch3 strobe every cycle with out_ready=1 → grants alternate 0,3,0,3…; drops accumulate (each channel granted every other cycle), no starvation.
